// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory read-port arbiter.
package imem_arb_pkg;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int unsigned STARVE_W = 4;

  typedef logic [STARVE_W-1:0] starve_cnt_t;

  localparam starve_cnt_t STARVE_MAX = '1;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_rsp_t;

  function automatic starve_cnt_t starve_inc(starve_cnt_t cnt);
    return (cnt == STARVE_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Request/response and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if #(
  parameter int unsigned AW = 10
);

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic          req0_ready;
  logic          flush0;
  logic          rsp0_valid;
  logic [31:0]   rsp0_data;
  logic          rsp0_err;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic          req1_ready;
  logic          rsp1_valid;
  logic [31:0]   rsp1_data;
  logic          rsp1_err;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_value;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, flush0, req1_valid, req1_addr, mem_value,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err, mem_addr
  );

  // Requesters plus the attached memory.
  modport master (
    output req0_valid, req0_addr, flush0, req1_valid, req1_addr, mem_value,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err, mem_addr
  );

endinterface

// File: rtl/imem_rsp_reg.sv
// Per-port response register: captures one granted read, valid for one cycle.
module imem_rsp_reg
  import imem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        grant,
  input  logic        kill,
  input  logic        err,
  input  logic [31:0] data,
  output imem_rsp_t   rsp
);

  imem_rsp_t rsp_q, rsp_d;

  // A killed grant still updates data/err; only the valid pulse is suppressed.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_d.valid = grant && !kill;
    if (grant) begin
      rsp_d.err  = err;
      rsp_d.data = err ? 32'h0 : data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Valid is masked while reset is held so a response due in a reset cycle is dropped.
  always_comb begin
    rsp       = rsp_q;
    rsp.valid = rsp_q.valid && !rst;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Fixed-priority arbiter (fetch first) with a starvation guard for the data/debug port,
// sharing the combinational instruction-memory read port.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned  LENGTH       = 1024,
  parameter int unsigned  STARVE_LIMIT = 4,
  localparam int unsigned AW           = $clog2(LENGTH)
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  starve_cnt_t   starve_cnt_q, starve_cnt_d;
  logic          override;
  logic [1:0]    grant;
  logic [AW-1:0] gnt_addr;
  logic          gnt_err;
  imem_rsp_t     rsp0, rsp1;

  always_comb begin
    override       = (32'(starve_cnt_q) >= STARVE_LIMIT) && bus.req1_valid;
    bus.req0_ready = !rst && bus.req0_valid && !override;
    bus.req1_ready = !rst && bus.req1_valid && (!bus.req0_valid || override);
  end

  assign grant[PORT_FETCH] = bus.req0_valid && bus.req0_ready;
  assign grant[PORT_DATA]  = bus.req1_valid && bus.req1_ready;

  // Idle cycles present the fetch address so the memory tracks the likely next fetch.
  assign gnt_addr     = grant[PORT_DATA] ? bus.req1_addr : bus.req0_addr;
  assign bus.mem_addr = gnt_addr;

  // Reject anything that would read past the last full word instead of wrapping.
  assign gnt_err = (gnt_addr[1:0] != 2'b00) || (32'(gnt_addr) > LENGTH - 32'd4);

  always_comb begin
    if (!bus.req1_valid || grant[PORT_DATA]) begin
      starve_cnt_d = '0;
    end else begin
      starve_cnt_d = starve_inc(starve_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  imem_rsp_reg u_rsp0 (
    .clk   (clk),
    .rst   (rst),
    .grant (grant[PORT_FETCH]),
    .kill  (bus.flush0),
    .err   (gnt_err),
    .data  (bus.mem_value),
    .rsp   (rsp0)
  );

  imem_rsp_reg u_rsp1 (
    .clk   (clk),
    .rst   (rst),
    .grant (grant[PORT_DATA]),
    .kill  (1'b0),
    .err   (gnt_err),
    .data  (bus.mem_value),
    .rsp   (rsp1)
  );

  assign bus.rsp0_valid = rsp0.valid;
  assign bus.rsp0_data  = rsp0.data;
  assign bus.rsp0_err   = rsp0.err;
  assign bus.rsp1_valid = rsp1.valid;
  assign bus.rsp1_data  = rsp1.data;
  assign bus.rsp1_err   = rsp1.err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: driver predicts grants/responses, monitor checks outputs.
module tb_imem_arbiter;

  localparam int unsigned LENGTH       = 1024;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned AW           = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_arbiter_if #(.AW(AW)) bus ();

  imem_arbiter #(
    .LENGTH       (LENGTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [LENGTH/4];
  assign bus.mem_value = mem[bus.mem_addr[AW-1:2]];

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t expq [2][$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   wait1 = 0;  // consecutive cycles port 1 has been left waiting

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model_rsp(input int due, input logic [AW-1:0] a);
    exp_t e;
    int   ai;
    ai     = int'(a);
    e.due  = due;
    e.err  = (ai % 4 != 0) || (ai > int'(LENGTH) - 4);
    e.data = e.err ? 32'h0 : mem[ai / 4];
    return e;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int a;
    case ($urandom_range(0, 3))
      0:       a = 4 * $urandom_range(0, LENGTH / 4 - 1);
      1:       a = int'(LENGTH) - 4 * $urandom_range(0, 2) - $urandom_range(0, 3);
      2:       a = 4 * $urandom_range(0, LENGTH / 4 - 1) + $urandom_range(1, 3);
      default: a = $urandom_range(0, LENGTH - 1);
    endcase
    return a[AW-1:0];
  endfunction

  // One cycle of stimulus; predicts grants from the arbitration rules and queues responses.
  task automatic drive(input logic r, input logic v0, input logic [AW-1:0] a0, input logic f0,
                       input logic v1, input logic [AW-1:0] a1,
                       output logic g0, output logic g1);
    @(posedge clk);
    #1;
    rst            = r;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.flush0     = f0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    if (r) begin
      for (int p = 0; p < 2; p++) begin
        while (expq[p].size() > 0 && expq[p][0].due == cyc) void'(expq[p].pop_front());
      end
    end
    g1 = !r && v1 && (!v0 || wait1 >= int'(STARVE_LIMIT));
    g0 = !r && v0 && !g1;
    @(negedge clk);
    chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
    chk("mem_addr", 32'(bus.mem_addr), g1 ? 32'(a1) : 32'(a0));
    if (g0 && !f0) expq[0].push_back(model_rsp(cyc + 1, a0));
    if (g1) expq[1].push_back(model_rsp(cyc + 1, a1));
    wait1 = (r || !v1 || g1) ? 0 : ((wait1 < 15) ? wait1 + 1 : 15);
  endtask

  task automatic mon(input int p, input logic v, input logic [31:0] d, input logic e);
    string nm;
    exp_t  x;
    nm = (p == 0) ? "rsp0" : "rsp1";
    if (expq[p].size() > 0 && expq[p][0].due == cyc) begin
      x = expq[p].pop_front();
      chk({nm, "_valid"}, 32'(v), 32'd1);
      chk({nm, "_data"}, d, x.data);
      chk({nm, "_err"}, 32'(e), 32'(x.err));
    end else begin
      chk({nm, "_valid_idle"}, 32'(v), 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, bus.rsp0_valid, bus.rsp0_data, bus.rsp0_err);
      mon(1, bus.rsp1_valid, bus.rsp1_data, bus.rsp1_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          g0, g1, p0, p1, f0, r;
    logic [AW-1:0] a0, a1;

    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.flush0     = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    for (int i = 0; i < int'(LENGTH / 4); i++) mem[i] = $urandom;
    mem[4] = 32'h0011_2233;

    // Reset: requests are ignored and response registers are cleared.
    drive(1'b1, 1'b1, 10'h010, 1'b0, 1'b1, 10'h020, g0, g1);
    chk("rst_rsp0_data", bus.rsp0_data, 32'h0);
    chk("rst_rsp0_err", 32'(bus.rsp0_err), 32'h0);
    chk("rst_rsp1_data", bus.rsp1_data, 32'h0);
    chk("rst_rsp1_err", 32'(bus.rsp1_err), 32'h0);
    drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, g0, g1);

    // Basic fetch.
    drive(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, 10'h000, g0, g1);
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, g0, g1);

    // Both ports hammering: port 1 wins every fifth cycle.
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 10'h040, 1'b0, 1'b1, 10'h080, g0, g1);
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, g0, g1);

    // Port-1 boundary addresses.
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h002, g0, g1);
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'(LENGTH - 2), g0, g1);
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'(LENGTH - 4), g0, g1);
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, g0, g1);

    // Flush then a normal fetch.
    drive(1'b0, 1'b1, 10'h030, 1'b1, 1'b0, 10'h000, g0, g1);
    drive(1'b0, 1'b1, 10'h034, 1'b0, 1'b0, 10'h000, g0, g1);
    drive(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, g0, g1);

    // Reset in the cycle after a grant, then recovery.
    drive(1'b0, 1'b1, 10'h050, 1'b0, 1'b0, 10'h000, g0, g1);
    drive(1'b1, 1'b1, 10'h054, 1'b0, 1'b1, 10'h058, g0, g1);
    drive(1'b1, 1'b1, 10'h054, 1'b0, 1'b1, 10'h058, g0, g1);
    drive(1'b0, 1'b1, 10'h054, 1'b0, 1'b0, 10'h000, g0, g1);
    drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, g0, g1);

    // Random traffic; a waiting requester holds its address until granted.
    p0 = 1'b0;
    p1 = 1'b0;
    a0 = '0;
    a1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0) begin
        p0 = ($urandom_range(0, 3) != 0);
        a0 = rand_addr();
      end
      if (!p1) begin
        p1 = ($urandom_range(0, 2) == 0);
        a1 = rand_addr();
      end
      f0 = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 63) == 0);
      drive(r, p0, a0, f0, p1, a1, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, g0, g1);
    chk("drain_q0", 32'(expq[0].size()), 32'd0);
    chk("drain_q1", 32'(expq[1].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single combinational read port of the instruction memory between two requesters: port 0 (IF-stage instruction fetch) and port 1 (data-side/debug word read). Fixed priority goes to fetch, with a starvation guard for port 1. Each granted read is captured into a registered per-port response one cycle later, with alignment and range checking. The block sits between the IF/MEM stages and the instruction memory instance.

## Interface
- LENGTH, 1024: memory size in bytes; must match the attached memory.
- STARVE_LIMIT, 4: consecutive denied cycles after which port 1 overrides port 0; range 1..15.
- AW, $clog2(LENGTH): address width (derived; not overridden).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  fetch request.
- req0_addr  in  AW  fetch byte address.
- req0_ready  out  1  fetch request accepted this cycle.
- flush0  in  1  cancel the port-0 response currently being captured.
- rsp0_valid  out  1  fetch response valid, one-cycle pulse.
- rsp0_data  out  32  fetched word.
- rsp0_err  out  1  misaligned or out-of-range fetch.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err: same meanings for port 1; port 1 has no flush.
- mem_addr  out  AW  address driven to the memory; combinational from the grant.
- mem_value  in  32  memory read data; combinational from mem_addr.

## Operation
- At most one grant per cycle. A grant is a handshake: valid && ready.
- Arbitration:
  - override = (starve_cnt >= STARVE_LIMIT) && req1_valid.
  - req0_ready = !rst && req0_valid && !override.
  - req1_ready = !rst && req1_valid && (!req0_valid || override).
- mem_addr = req1_addr when port 1 is granted; otherwise req0_addr (including when idle).
- starve_cnt (4 bits, saturating at 15):
  - increments when req1_valid && !req1_ready;
  - clears on a port-1 grant or when req1_valid is low.
- Error check per granted request: err = (addr[1:0] != 0) || (addr > LENGTH-4).
  - On error, data is 0. No wrap-around read is ever returned.
- Response capture at the grant edge:
  - rspN_valid <= granted;
  - rspN_data <= err ? 0 : mem_value;
  - rspN_err <= err.
  - When not granted: rspN_valid <= 0; data and err hold their previous values.
- Flush: flush0 high in a port-0 grant cycle forces rsp0_valid to 0 next cycle. flush0 has no effect in other cycles.
- Responses have no backpressure. Requesters must accept a response in the cycle it is presented.

## Timing
- Reset values: rsp*_valid=0, rsp*_data=0, rsp*_err=0, starve_cnt=0.
  - req*_ready=0 while rst is high.
  - mem_addr follows req0_addr.
- Latency: a request granted in cycle t produces its response in cycle t+1, valid for exactly one cycle.
- Throughput: one response total per cycle.
  - Back-to-back port-0 grants give rsp0_valid continuously high.
- Simultaneous requests: port 0 wins unless override is true.
  - The loser keeps valid high; its address must stay stable until it is granted.
- Reset asserted mid-operation: any response due the next cycle is dropped (rsp*_valid=0), and starve_cnt clears.
- flush0 and a port-1 grant never collide, because grants are exclusive.

## Structure
- Package imem_arb_pkg:
  - port index constants PORT_FETCH=0, PORT_DATA=1;
  - starve counter width (4);
  - a packed response typedef {valid, err, data[31:0]}.
- Sub-module imem_rsp_reg: the per-port response register. It takes grant, err, data and kill (flush), and is instantiated twice (kill tied to 0 for port 1).
- Top level contains only arbitration, the starvation counter, the address mux and the error check.

## Test plan
- Reset, then port 0 requests addr 0x10 with mem_value 0x00112233:
  - req0_ready=1 the same cycle;
  - next cycle rsp0_valid=1, rsp0_data=0x00112233, rsp0_err=0.
- Both ports request every cycle, STARVE_LIMIT=4:
  - port 0 granted for 4 cycles, then port 1 granted on the 5th;
  - starve_cnt returns to 0; pattern repeats.
- Misaligned addr 0x02 and addr LENGTH-2 on port 1:
  - rsp1_valid=1, rsp1_err=1, rsp1_data=0 each time.
- Port-0 grant with flush0=1 → rsp0_valid=0 next cycle. The following unflushed grant responds normally.
- rst asserted in the cycle after a grant:
  - all rsp*_valid=0 while rst is high;
  - ready outputs 0;
  - after release, the first request completes with 1-cycle latency.
- Port 1 alone, addr LENGTH-4 → rsp1_err=0 and data equals the mem_value presented at that address.
